// File: rtl/otter_pl_pkg.sv
// Shared types for the OTTER pipelined front end.
//  fetch_state_t : fetch sequencer states
//  if_id_t       : IF/ID pipeline register contents
//  skid_entry_t  : one parked instruction {ir, pc}
//  NOP_INSTR     : bubble instruction (addi x0,x0,0)
package otter_pl_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,  // no response in flight
    RUN  = 2'd1,  // response for req_pc is on imem_rdata this cycle
    HOLD = 2'd2   // skid full, nothing in flight
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } skid_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic if_id_t if_id_bubble(input logic [31:0] nop);
    if_id_t b;
    b.ir      = nop;
    b.pc      = '0;
    b.next_pc = '0;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/otter_fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory port, hazard unit,
// EX redirect source and decode.
//  master : fetch stage side (drives imem request, IF/ID, misaligned pulse)
//  slave  : environment side (memory, hazard unit, EX, decode)
interface otter_fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_next_pc;
  logic        if_id_valid;
  logic        misaligned_redirect;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, imem_rden,
    output if_id_ir, if_id_pc, if_id_next_pc, if_id_valid,
    output misaligned_redirect
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, imem_rden,
    input  if_id_ir, if_id_pc, if_id_next_pc, if_id_valid,
    input  misaligned_redirect
  );
endinterface

// File: rtl/otter_fetch_skid.sv
// One-entry holding register for an instruction that returned from memory
// while decode was stalled.
//  clk_i, rst_i : clock, synchronous active-high reset
//  load_i       : capture entry_i, mark full
//  clear_i      : mark empty (wins over load_i)
//  entry_i      : {ir, pc} to park
//  entry_o      : parked {ir, pc}
//  valid_o      : entry is full
module otter_fetch_skid
  import otter_pl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  skid_entry_t entry_i,
  output skid_entry_t entry_o,
  output logic        valid_o
);

  skid_entry_t entry_q;
  logic        valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      valid_q <= 1'b1;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage. Owns the PC, issues word reads to a
// 1-cycle-latency synchronous instruction port, and drives the IF/ID
// register. Decode stalls are absorbed by a 1-entry skid buffer; EX
// redirects flush IF and IF/ID and restart fetch at the target.
//  CLK, RESET : clock, synchronous active-high reset
//  bus        : otter_fetch_stage_if.master
//    stall, redirect, redirect_pc   control from hazard unit / EX
//    imem_addr, imem_rden, imem_rdata instruction memory port
//    if_id_ir/pc/next_pc/valid       IF/ID register to decode
//    misaligned_redirect             redirect target had low bits set
module otter_fetch_stage
  import otter_pl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = otter_pl_pkg::NOP_INSTR
) (
  input logic                 CLK,
  input logic                 RESET,
  otter_fetch_stage_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;   // address of the request now in flight
  if_id_t       if_id_q, if_id_d;

  logic         issue;
  logic         skid_load, skid_clear, skid_valid;
  skid_entry_t  skid_in, skid_out;
  logic [31:0]  redirect_tgt;

  // Low two bits are dropped rather than trapping here; the pulse lets the
  // rest of the core see that it happened.
  assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= FILL;
      pc_q     <= RESET_VEC;
      req_pc_q <= '0;
      if_id_q  <= if_id_bubble(NOP_INSTR);
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      if_id_q  <= if_id_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      state_d = FILL;
    end else if (bus.stall) begin
      // Only RUN has data arriving that must be parked.
      if (state_q == RUN) state_d = HOLD;
    end else begin
      state_d = RUN;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_id_d    = if_id_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    issue      = 1'b0;
    skid_in.ir = bus.imem_rdata;
    skid_in.pc = req_pc_q;

    if (bus.redirect) begin
      // Flush even under stall: whatever IF/ID holds is wrong-path.
      pc_d       = redirect_tgt;
      if_id_d    = if_id_bubble(NOP_INSTR);
      skid_clear = 1'b1;
    end else if (bus.stall) begin
      if (state_q == RUN) skid_load = 1'b1;
    end else begin
      issue = 1'b1;
      case (state_q)
        RUN: begin
          if_id_d.ir      = bus.imem_rdata;
          if_id_d.pc      = req_pc_q;
          if_id_d.next_pc = req_pc_q + 32'd4;
          if_id_d.valid   = 1'b1;
        end
        HOLD: begin
          // No request was issued while parked, so the skid holds exactly
          // the next instruction in program order.
          if_id_d.ir      = skid_out.ir;
          if_id_d.pc      = skid_out.pc;
          if_id_d.next_pc = skid_out.pc + 32'd4;
          if_id_d.valid   = skid_valid;
          skid_clear      = 1'b1;
        end
        default: if_id_d = if_id_bubble(NOP_INSTR);
      endcase
    end

    if (issue) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 32'd4;
    end
  end

  otter_fetch_skid u_skid (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .entry_i (skid_in),
    .entry_o (skid_out),
    .valid_o (skid_valid)
  );

  assign bus.imem_addr           = pc_q;
  assign bus.imem_rden           = !RESET && issue;
  // Combinational pulse in the cycle the misaligned redirect is accepted.
  assign bus.misaligned_redirect = !RESET && bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign bus.if_id_ir            = if_id_q.ir;
  assign bus.if_id_pc            = if_id_q.pc;
  assign bus.if_id_next_pc       = if_id_q.next_pc;
  assign bus.if_id_valid         = if_id_q.valid;

endmodule

// File: tb/tb_otter_fetch_stage.sv
module tb_otter_fetch_stage;

  logic CLK;
  logic RESET;
  int   vectors;
  int   miscompares;

  otter_fetch_stage_if bus();

  otter_fetch_stage #(.RESET_VEC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: word at addr reads as 1000_0000|addr, one cycle later.
  always @(posedge CLK)
    if (bus.imem_rden) bus.imem_rdata <= 32'h1000_0000 | bus.imem_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: fetch as a stream of addresses
  logic [31:0] m_pc;
  logic [31:0] m_infl[$];   // requests whose data arrives this cycle
  logic [31:0] m_skid[$];   // instructions returned but not yet delivered
  logic [31:0] m_ir, m_ipc, m_inpc;
  logic        m_v;

  task automatic m_bubble();
    m_ir = 32'h13; m_ipc = 0; m_inpc = 0; m_v = 0;
  endtask

  task automatic m_deliver(input logic [31:0] p);
    m_ir = 32'h1000_0000 | p; m_ipc = p; m_inpc = p + 32'd4; m_v = 1;
  endtask

  initial begin
    m_pc = 0; m_bubble();
    @(posedge CLK);            // first reset edge
    forever begin
      @(negedge CLK);
      chk("rden",  bus.imem_rden, !RESET && !bus.redirect && !bus.stall);
      chk("addr",  bus.imem_addr, m_pc);
      chk("ir",    bus.if_id_ir, m_ir);
      chk("pc",    bus.if_id_pc, m_ipc);
      chk("npc",   bus.if_id_next_pc, m_inpc);
      chk("valid", bus.if_id_valid, m_v);
      chk("misal", bus.misaligned_redirect,
          !RESET && bus.redirect && (bus.redirect_pc[1:0] != 2'b00));
      // advance model to what the coming edge must produce
      if (RESET) begin
        m_pc = 0; m_infl.delete(); m_skid.delete(); m_bubble();
      end else if (bus.redirect) begin
        m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        m_infl.delete(); m_skid.delete(); m_bubble();
      end else if (bus.stall) begin
        if (m_infl.size() != 0) m_skid.push_back(m_infl.pop_front());
      end else begin
        if (m_skid.size() != 0)      m_deliver(m_skid.pop_front());
        else if (m_infl.size() != 0) m_deliver(m_infl.pop_front());
        else                         m_bubble();
        m_infl.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- stimulus
  task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
    @(posedge CLK); #1;
    RESET = r; bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic lit_ifid(input string nm, input logic v, input logic [31:0] p);
    chk({nm, ".valid"}, bus.if_id_valid, v);
    chk({nm, ".pc"},    bus.if_id_pc, p);
    chk({nm, ".ir"},    bus.if_id_ir, v ? (32'h1000_0000 | p) : 32'h13);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    RESET = 1; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    cyc(1, 0, 0, 0);
    lit_ifid("reset", 0, 0);
    chk("reset.npc", bus.if_id_next_pc, 0);
    chk("reset.rden", bus.imem_rden, 0);

    // 1: free-running fetch
    cyc(0, 0, 0, 0);                        // A0
    chk("a0.rden", bus.imem_rden, 1);
    chk("a0.addr", bus.imem_addr, 0);
    lit_ifid("a0", 0, 0);
    cyc(0, 0, 0, 0);                        // A1
    lit_ifid("a1", 0, 0);
    cyc(0, 0, 0, 0);                        // A2
    lit_ifid("a2", 1, 0);
    chk("a2.npc", bus.if_id_next_pc, 4);

    // 2: stall while pc=8 response arrives
    cyc(0, 1, 0, 0);                        // A3
    lit_ifid("a3", 1, 4);
    chk("a3.rden", bus.imem_rden, 0);
    cyc(0, 1, 0, 0);  lit_ifid("a4", 1, 4);
    cyc(0, 1, 0, 0);  lit_ifid("a5", 1, 4);
    cyc(0, 0, 0, 0);                        // A6
    lit_ifid("a6", 1, 4);
    chk("a6.addr", bus.imem_addr, 32'hC);
    cyc(0, 0, 0, 0);  lit_ifid("a7", 1, 8);
    cyc(0, 0, 0, 0);  lit_ifid("a8", 1, 32'hC);

    // 3: redirect under stall
    cyc(0, 1, 1, 32'h200);                  // A9
    chk("a9.rden", bus.imem_rden, 0);
    cyc(0, 0, 0, 0);                        // A10
    lit_ifid("a10", 0, 0);
    chk("a10.addr", bus.imem_addr, 32'h200);
    chk("a10.rden", bus.imem_rden, 1);
    cyc(0, 0, 0, 0);  lit_ifid("a11", 0, 0);
    cyc(0, 0, 0, 0);  lit_ifid("a12", 1, 32'h200);

    // 4: misaligned redirect
    cyc(0, 0, 1, 32'h203);                  // A13
    chk("a13.misal", bus.misaligned_redirect, 1);
    cyc(0, 0, 0, 0);                        // A14
    chk("a14.misal", bus.misaligned_redirect, 0);
    chk("a14.addr", bus.imem_addr, 32'h200);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);  lit_ifid("a16", 1, 32'h200);

    // 5: wrap at top of address space
    cyc(0, 0, 1, 32'hFFFF_FFFC);            // A17
    cyc(0, 0, 0, 0);                        // A18
    chk("a18.addr", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);                        // A19
    chk("a19.addr", bus.imem_addr, 0);
    chk("a19.rden", bus.imem_rden, 1);
    cyc(0, 0, 0, 0);                        // A20
    lit_ifid("a20", 1, 32'hFFFF_FFFC);
    chk("a20.npc", bus.if_id_next_pc, 0);

    // 6: reset while holding a skid entry
    cyc(0, 1, 0, 0);  lit_ifid("a21", 1, 0); // A21 parks pc=4
    cyc(1, 0, 0, 0);                        // A22
    chk("a22.rden", bus.imem_rden, 0);
    cyc(0, 0, 0, 0);                        // A23
    lit_ifid("a23", 0, 0);
    chk("a23.addr", bus.imem_addr, 0);
    chk("a23.rden", bus.imem_rden, 1);
    cyc(0, 0, 0, 0);  lit_ifid("a24", 0, 0);
    cyc(0, 0, 0, 0);  lit_ifid("a25", 1, 0);

    // extra corners: redirect from HOLD, stall in FILL, misaligned under stall
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 32'h40);
    cyc(0, 1, 0, 0);
    chk("fillstall.rden", bus.imem_rden, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h81);
    chk("misal_stall", bus.misaligned_redirect, 1);
    repeat (3) cyc(0, 0, 0, 0);
    lit_ifid("tail", 1, 32'h80);
    repeat (2) cyc(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
